// File: rtl/atto_link_pkg.sv
// Shared definitions for the toggle-link transmit arbiter and its helpers.
// Holds the FSM state encoding and the reset values of the two toggle wires.
package atto_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOCK = 2'd2
    } link_state_e;

    localparam logic LINK_P_RST = 1'b1;
    localparam logic LINK_N_RST = 1'b0;

endpackage

// File: rtl/output_link_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans the request vector starting at ptr_i, wrapping modulo N. It returns
// the first set bit as a one-hot vector and as an index. N need not be a
// power of two. ptr_i is expected to stay below N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    // Walk the N candidates in priority order; the first requester found wins.
    always_comb begin
        int idx;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[idx]) begin
                any_o         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/output_link_arbiter.sv
// output_link_arbiter: shares one two-phase toggle link among PORTS requesters.
// Arbitration is round-robin at packet granularity. The winner keeps the link
// until its tail flit has been acknowledged. Only one flit is ever in flight.
// Build option ATTO_LINK_CHECK_EN adds the sticky link_err_o output. That
// output flags a half-mismatch between the link pair and the acknowledge pair,
// and it freezes the FSM until reset.
module output_link_arbiter
    import atto_link_pkg::*;
#(
    parameter int  PORTS  = 4,
    parameter int  FLIT_W = 32,
    localparam int PTR_W  = $clog2(PORTS)
) (
    input  logic                      clka,
    input  logic                      rsta_n,
    input  logic [PORTS-1:0]          req_i,
    input  logic [PORTS-1:0]          last_i,
    input  logic [PORTS*FLIT_W-1:0]   flit_i,
    output logic [PORTS-1:0]          gnt_o,
    output logic [FLIT_W-1:0]         link_flit_o,
    output logic                      link_p_o,
    output logic                      link_n_o,
    input  logic                      ack_p_i,
    input  logic                      ack_n_i
`ifdef ATTO_LINK_CHECK_EN
    ,
    output logic                      link_err_o
`endif
);

    link_state_e        state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               tail_q, tail_d;
    logic [FLIT_W-1:0]  link_flit_q, link_flit_d;
    logic               link_p_q, link_p_d;
    logic               link_n_q, link_n_d;
    logic [PORTS-1:0]   gnt_q, gnt_d;

    logic               link_idle;
    logic               fsm_en;
    logic               send;
    logic [PTR_W-1:0]   send_port;
    logic [PORTS-1:0]   pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(
        .N     (PORTS),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .req_i     (req_i),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // The link is free when the downstream has echoed both toggle wires back.
    assign link_idle = (link_p_q == ack_p_i) && (link_n_q == ack_n_i);

`ifdef ATTO_LINK_CHECK_EN
    logic link_err_q, link_err_d;

    // A half-mismatch (exactly one wire out of step) is sticky until reset.
    always_comb begin
        link_err_d = link_err_q | ((link_p_q ^ ack_p_i) != (link_n_q ^ ack_n_i));
    end

    // Error flag register; only the asynchronous reset clears it.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            link_err_q <= 1'b0;
        end else begin
            link_err_q <= link_err_d;
        end
    end

    assign fsm_en     = !link_err_q;
    assign link_err_o = link_err_q;
`else
    assign fsm_en = 1'b1;
`endif

    // Next-state logic. It picks an owner in IDLE and follows that owner's
    // packet through WAIT and LOCK. A send is launched only when the link is free.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        tail_d      = tail_q;
        link_flit_d = link_flit_q;
        link_p_d    = link_p_q;
        link_n_d    = link_n_q;
        gnt_d       = '0;
        send        = 1'b0;
        send_port   = owner_q;

        if (fsm_en) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_d   = pick_idx;
                        send_port = pick_idx;
                        send      = 1'b1;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (link_idle) begin
                        if (tail_q) begin
                            rr_ptr_d = (owner_q == PTR_W'(PORTS - 1)) ? '0 : owner_q + PTR_W'(1);
                            state_d  = IDLE;
                        end else if (req_i[owner_q]) begin
                            send = 1'b1;
                        end else begin
                            state_d = LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (req_i[owner_q]) begin
                        send    = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (send) begin
                link_flit_d = flit_i[int'(send_port)*FLIT_W +: FLIT_W];
                tail_d      = last_i[send_port];
                link_p_d    = ~link_p_q;
                link_n_d    = ~link_n_q;
                gnt_d       = (state_q == IDLE) ? pick_oh : (PORTS'(1) << owner_q);
            end
        end
    end

    // State and registered link outputs; reset restores the idle link pair p=1/n=0.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            tail_q      <= 1'b0;
            link_flit_q <= '0;
            link_p_q    <= LINK_P_RST;
            link_n_q    <= LINK_N_RST;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            tail_q      <= tail_d;
            link_flit_q <= link_flit_d;
            link_p_q    <= link_p_d;
            link_n_q    <= link_n_d;
            gnt_q       <= gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign link_flit_o = link_flit_q;
    assign link_p_o    = link_p_q;
    assign link_n_o    = link_n_q;

endmodule

// File: tb/tb_output_link_arbiter.sv
// Testbench for output_link_arbiter (PORTS=4, FLIT_W=32).
// A registered downstream model echoes the link pair back one cycle later.
// Requester sources are queued per port. Expected grants go to a scoreboard
// queue when stimulus is loaded, and are popped as grants appear.
// With ATTO_LINK_CHECK_EN defined, the sticky link error is exercised.
module tb_output_link_arbiter;

    localparam int PORTS  = 4;
    localparam int FLIT_W = 32;

    typedef struct packed {
        logic [1:0]        port;
        logic [FLIT_W-1:0] flit;
        logic              last;
    } item_t;

    logic                    clka = 1'b0;
    logic                    rsta_n;
    logic [PORTS-1:0]        req_i;
    logic [PORTS-1:0]        last_i;
    logic [PORTS*FLIT_W-1:0] flit_i;
    logic [PORTS-1:0]        gnt_o;
    logic [FLIT_W-1:0]       link_flit_o;
    logic                    link_p_o;
    logic                    link_n_o;
    logic                    ack_p_i;
    logic                    ack_n_i;
`ifdef ATTO_LINK_CHECK_EN
    logic                    link_err_o;
`endif

    logic ack_p_q, ack_n_q;
    logic ack_hold, flip_p, flip_n;

    item_t src_q[$];
    item_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    output_link_arbiter #(
        .PORTS  (PORTS),
        .FLIT_W (FLIT_W)
    ) dut (
        .clka        (clka),
        .rsta_n      (rsta_n),
        .req_i       (req_i),
        .last_i      (last_i),
        .flit_i      (flit_i),
        .gnt_o       (gnt_o),
        .link_flit_o (link_flit_o),
        .link_p_o    (link_p_o),
        .link_n_o    (link_n_o),
        .ack_p_i     (ack_p_i),
        .ack_n_i     (ack_n_i)
`ifdef ATTO_LINK_CHECK_EN
        ,
        .link_err_o  (link_err_o)
`endif
    );

    // 10-unit clock
    always #5 clka = ~clka;

    // Downstream input register: echoes the link pair one cycle later unless held
    always @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ack_p_q <= 1'b1;
            ack_n_q <= 1'b0;
        end else if (!ack_hold) begin
            ack_p_q <= link_p_o;
            ack_n_q <= link_n_o;
        end
    end

    assign ack_p_i = ack_p_q ^ flip_p;
    assign ack_n_i = ack_n_q ^ flip_n;

    // Present the head flit of each port's source queue
    task automatic drive_sources();
        req_i  = '0;
        last_i = '0;
        flit_i = '0;
        for (int p = 0; p < PORTS; p++) begin
            bit found;
            found = 0;
            for (int i = 0; i < src_q.size(); i++) begin
                if (!found && src_q[i].port == 2'(p)) begin
                    found                      = 1;
                    req_i[p]                   = 1'b1;
                    last_i[p]                  = src_q[i].last;
                    flit_i[p*FLIT_W +: FLIT_W] = src_q[i].flit;
                end
            end
        end
    endtask

    // Retire the head flit of every granted port
    task automatic consume(input logic [PORTS-1:0] g);
        for (int p = 0; p < PORTS; p++) begin
            if (g[p]) begin
                int idx;
                idx = -1;
                for (int i = 0; i < src_q.size(); i++) begin
                    if (idx < 0 && src_q[i].port == 2'(p)) idx = i;
                end
                if (idx >= 0) src_q.delete(idx);
            end
        end
    endtask

    task automatic add_src(input int port, input logic [FLIT_W-1:0] flit, input logic last);
        item_t it;
        it.port = 2'(port);
        it.flit = flit;
        it.last = last;
        src_q.push_back(it);
    endtask

    task automatic expect_gnt(input int port, input logic [FLIT_W-1:0] flit);
        item_t it;
        it.port = 2'(port);
        it.flit = flit;
        it.last = 1'b0;
        exp_q.push_back(it);
    endtask

    // Advance until a grant appears or the budget runs out; sources follow grants
    task automatic wait_gnt(input int budget, output logic [PORTS-1:0] g,
                            output logic [FLIT_W-1:0] f, output bit to);
        bit seen;
        seen = 0;
        g    = '0;
        f    = '0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clka);
            if (gnt_o !== '0) begin
                seen = 1;
                g    = gnt_o;
                f    = link_flit_o;
                consume(gnt_o);
                drive_sources();
            end
        end
        to = !seen;
    endtask

    task automatic do_reset();
        @(negedge clka);
        rsta_n   = 1'b0;
        ack_hold = 1'b0;
        flip_p   = 1'b0;
        flip_n   = 1'b0;
        src_q.delete();
        exp_q.delete();
        drive_sources();
        @(negedge clka);
        rsta_n = 1'b1;
        @(negedge clka);
    endtask

    // Reset values after power-up and after an asynchronous mid-packet reset
    task automatic test_reset();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        bit                to;
        item_t             e;
        n_vec++;
        if (link_p_o !== 1'b1 || link_n_o !== 1'b0 || gnt_o !== '0 || link_flit_o !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_values: got p=%b n=%b gnt=%b flit=%h want p=1 n=0 gnt=0000 flit=0",
                     link_p_o, link_n_o, gnt_o, link_flit_o);
        end
        add_src(0, 32'hA5A5_0001, 1'b0);
        expect_gnt(0, 32'hA5A5_0001);
        drive_sources();
        e = exp_q.pop_front();
        wait_gnt(10, g, f, to);
        n_vec++;
        if (to || g !== (4'b0001 << e.port) || f !== e.flit || link_p_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_first_send: got gnt=%b flit=%h p=%b to=%0b want gnt=%b flit=%h p=0",
                     g, f, link_p_o, to, 4'b0001 << e.port, e.flit);
        end
        #2 rsta_n = 1'b0;
        #1;
        n_vec++;
        if (link_p_o !== 1'b1 || link_n_o !== 1'b0 || gnt_o !== '0 || link_flit_o !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_async: got p=%b n=%b gnt=%b flit=%h want p=1 n=0 gnt=0000 flit=0",
                     link_p_o, link_n_o, gnt_o, link_flit_o);
        end
        src_q.delete();
        exp_q.delete();
        drive_sources();
        @(negedge clka);
        rsta_n = 1'b1;
        @(negedge clka);
    endtask

    // One requester, three-flit packet, one link toggle per flit
    task automatic test_single_packet();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        logic              prev_p;
        bit                to;
        item_t             e;
        for (int i = 0; i < 3; i++) begin
            add_src(1, 32'h1111_0000 + 32'(i), (i == 2));
            expect_gnt(1, 32'h1111_0000 + 32'(i));
        end
        drive_sources();
        while (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            prev_p = link_p_o;
            wait_gnt(10, g, f, to);
            n_vec++;
            if (to || g !== (4'b0001 << e.port) || f !== e.flit || link_p_o !== ~prev_p || link_n_o !== prev_p) begin
                n_err++;
                $display("[TB] FAIL single_flit: got gnt=%b flit=%h p=%b n=%b to=%0b want gnt=%b flit=%h p=%b n=%b",
                         g, f, link_p_o, link_n_o, to, 4'b0001 << e.port, e.flit, ~prev_p, prev_p);
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            n_vec++;
            if (gnt_o !== '0) begin
                n_err++;
                $display("[TB] FAIL single_quiet: got gnt=%b want 0000", gnt_o);
            end
        end
    endtask

    // All four ports request single-flit packets; winners rotate 0,1,2,3,0,...
    task automatic test_round_robin();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        bit                to;
        item_t             e;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < PORTS; p++) begin
                add_src(p, 32'hC0DE_0000 + 32'(16 * r + p), 1'b1);
                expect_gnt(p, 32'hC0DE_0000 + 32'(16 * r + p));
            end
        end
        drive_sources();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_gnt(10, g, f, to);
            n_vec++;
            if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
                n_err++;
                $display("[TB] FAIL rr_order: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                         g, f, to, 4'b0001 << e.port, e.flit);
            end
        end
    endtask

    // Port 2 holds the link across a request gap while port 0 waits
    task automatic test_lock();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        bit                to;
        item_t             e;
        add_src(2, 32'h2222_0000, 1'b0);
        expect_gnt(2, 32'h2222_0000);
        drive_sources();
        e = exp_q.pop_front();
        wait_gnt(12, g, f, to);
        n_vec++;
        if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
            n_err++;
            $display("[TB] FAIL lock_first: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                     g, f, to, 4'b0001 << e.port, e.flit);
        end
        add_src(0, 32'h0000_00AA, 1'b1);
        drive_sources();
        for (int c = 0; c < 8; c++) begin
            @(negedge clka);
            n_vec++;
            if (gnt_o !== '0) begin
                n_err++;
                $display("[TB] FAIL lock_hold: got gnt=%b want 0000", gnt_o);
            end
        end
        add_src(2, 32'h2222_0001, 1'b1);
        expect_gnt(2, 32'h2222_0001);
        expect_gnt(0, 32'h0000_00AA);
        drive_sources();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_gnt(10, g, f, to);
            n_vec++;
            if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
                n_err++;
                $display("[TB] FAIL lock_resume: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                         g, f, to, 4'b0001 << e.port, e.flit);
            end
        end
    endtask

    // Acknowledge withheld for 10 cycles stalls the second flit
    task automatic test_backpressure();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        logic              p_hold;
        bit                to;
        item_t             e;
        add_src(3, 32'hBBBB_0000, 1'b0);
        add_src(3, 32'hBBBB_0001, 1'b1);
        expect_gnt(3, 32'hBBBB_0000);
        expect_gnt(3, 32'hBBBB_0001);
        drive_sources();
        e = exp_q.pop_front();
        wait_gnt(12, g, f, to);
        ack_hold = 1'b1;
        p_hold   = link_p_o;
        n_vec++;
        if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
            n_err++;
            $display("[TB] FAIL bp_first: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                     g, f, to, 4'b0001 << e.port, e.flit);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clka);
            n_vec++;
            if (gnt_o !== '0 || link_p_o !== p_hold) begin
                n_err++;
                $display("[TB] FAIL bp_stall: got gnt=%b p=%b want gnt=0000 p=%b", gnt_o, link_p_o, p_hold);
            end
        end
        ack_hold = 1'b0;
        @(negedge clka);
        n_vec++;
        if (gnt_o !== '0) begin
            n_err++;
            $display("[TB] FAIL bp_echo: got gnt=%b want 0000", gnt_o);
        end
        @(negedge clka);
        e = exp_q.pop_front();
        g = gnt_o;
        f = link_flit_o;
        consume(gnt_o);
        drive_sources();
        n_vec++;
        if (g !== (4'b0001 << e.port) || f !== e.flit || link_p_o !== ~p_hold) begin
            n_err++;
            $display("[TB] FAIL bp_release: got gnt=%b flit=%h p=%b want gnt=%b flit=%h p=%b",
                     g, f, link_p_o, 4'b0001 << e.port, e.flit, ~p_hold);
        end
        repeat (3) @(negedge clka);
    endtask

`ifdef ATTO_LINK_CHECK_EN
    // One wire out of step sets the sticky error and freezes sends until reset
    task automatic test_link_err();
        do_reset();
        n_vec++;
        if (link_err_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL err_reset: got err=%b want 0", link_err_o);
        end
        flip_p = 1'b1;
        @(negedge clka);
        n_vec++;
        if (link_err_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_set: got err=%b want 1", link_err_o);
        end
        flip_p = 1'b0;
        add_src(0, 32'hEEEE_0000, 1'b1);
        drive_sources();
        for (int c = 0; c < 5; c++) begin
            @(negedge clka);
            n_vec++;
            if (gnt_o !== '0 || link_p_o !== 1'b1 || link_err_o !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL err_freeze: got gnt=%b p=%b err=%b want gnt=0000 p=1 err=1",
                         gnt_o, link_p_o, link_err_o);
            end
        end
        do_reset();
        n_vec++;
        if (link_err_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL err_clear: got err=%b want 0", link_err_o);
        end
    endtask
`else
    // Without the checker a half-mismatch just looks like a busy link
    task automatic test_half_mismatch();
        logic [PORTS-1:0]  g;
        logic [FLIT_W-1:0] f;
        bit                to;
        item_t             e;
        do_reset();
        add_src(1, 32'h4444_0000, 1'b0);
        add_src(1, 32'h4444_0001, 1'b1);
        expect_gnt(1, 32'h4444_0000);
        expect_gnt(1, 32'h4444_0001);
        drive_sources();
        e = exp_q.pop_front();
        wait_gnt(10, g, f, to);
        flip_n = 1'b1;
        n_vec++;
        if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
            n_err++;
            $display("[TB] FAIL half_first: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                     g, f, to, 4'b0001 << e.port, e.flit);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clka);
            n_vec++;
            if (gnt_o !== '0) begin
                n_err++;
                $display("[TB] FAIL half_wait: got gnt=%b want 0000", gnt_o);
            end
        end
        flip_n = 1'b0;
        e = exp_q.pop_front();
        wait_gnt(4, g, f, to);
        n_vec++;
        if (to || g !== (4'b0001 << e.port) || f !== e.flit) begin
            n_err++;
            $display("[TB] FAIL half_resume: got gnt=%b flit=%h to=%0b want gnt=%b flit=%h",
                     g, f, to, 4'b0001 << e.port, e.flit);
        end
    endtask
`endif

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        rsta_n   = 1'b0;
        ack_hold = 1'b0;
        flip_p   = 1'b0;
        flip_n   = 1'b0;
        drive_sources();
        repeat (3) @(negedge clka);
        rsta_n = 1'b1;
        @(negedge clka);

        test_reset();
        test_single_packet();
        test_round_robin();
        test_lock();
        test_backpressure();
`ifdef ATTO_LINK_CHECK_EN
        test_link_err();
`else
        test_half_mismatch();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
